// File: rtl/l1_dcache_if.sv
// CPU-side and L2-side bus bundles for the L1 data cache.
// master drives the request; slave answers it.
interface l1_dcache_cpu_if;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        hit;

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_rdata, mem_resp, hit
    );
    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_rdata, mem_resp, hit
    );
endinterface

interface l1_dcache_pmem_if;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );
    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache with flop-based arrays.
// Hits finish combinationally in IDLE; misses go through WRITEBACK and/or ALLOCATE.
module l1_dcache #(
    parameter int S_INDEX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    l1_dcache_cpu_if.slave    cpu,
    l1_dcache_pmem_if.master  pmem
);
    localparam int S_OFFSET = 5;
    localparam int SETS     = 1 << S_INDEX;
    localparam int TAG_W    = 32 - S_INDEX - S_OFFSET;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;

    state_e              state_q, state_d;
    logic [SETS-1:0]     valid_q, valid_d;
    logic [SETS-1:0]     dirty_q, dirty_d;
    logic                missed_q, missed_d;
    logic [TAG_W-1:0]    tag_q  [SETS];
    logic [255:0]        data_q [SETS];
    logic [31:S_OFFSET]  missAddr_q;

    logic                req;
    logic [S_INDEX-1:0]  reqIndex, missIndex;
    logic [TAG_W-1:0]    reqTag, missTag;
    logic [2:0]          reqWord;
    logic [7:0]          wordBase;
    logic                lookupHit, startMiss, writeHit, wbDone, fillDone;
    logic [31:0]         mergedWord;
    logic [1:0]          unusedAddrBits;

    assign req            = cpu.mem_read | cpu.mem_write;
    assign reqIndex       = cpu.mem_address[S_OFFSET +: S_INDEX];
    assign reqTag         = cpu.mem_address[31 -: TAG_W];
    assign reqWord        = cpu.mem_address[4:2];
    assign wordBase       = {reqWord, 5'b0};
    assign unusedAddrBits = cpu.mem_address[1:0];
    assign missIndex      = missAddr_q[S_OFFSET +: S_INDEX];
    assign missTag        = missAddr_q[31 -: TAG_W];

    assign lookupHit = valid_q[reqIndex] && (tag_q[reqIndex] == reqTag);
    assign startMiss = (state_q == IDLE) && req && !lookupHit;
    assign writeHit  = (state_q == IDLE) && cpu.mem_write && lookupHit;
    assign wbDone    = (state_q == WRITEBACK) && pmem.pmem_resp;
    assign fillDone  = (state_q == ALLOCATE) && pmem.pmem_resp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            valid_q  <= '0;
            dirty_q  <= '0;
            missed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
            missed_q <= missed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (startMiss)
                           state_d = (valid_q[reqIndex] && dirty_q[reqIndex]) ? WRITEBACK : ALLOCATE;
            WRITEBACK: if (pmem.pmem_resp) state_d = ALLOCATE;
            ALLOCATE:  if (pmem.pmem_resp) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // The miss is served from the latched line address, so the fill still lands correctly
    // if the CPU drops its request part way through.
    always_comb begin
        cpu.mem_resp      = 1'b0;
        pmem.pmem_read    = 1'b0;
        pmem.pmem_write   = 1'b0;
        pmem.pmem_address = {missAddr_q, {S_OFFSET{1'b0}}};
        unique case (state_q)
            IDLE:      cpu.mem_resp = req && lookupHit;
            WRITEBACK: begin
                pmem.pmem_write   = 1'b1;
                pmem.pmem_address = {tag_q[missIndex], missIndex, {S_OFFSET{1'b0}}};
            end
            ALLOCATE:  pmem.pmem_read = 1'b1;
            default:   cpu.mem_resp = 1'b0;
        endcase
    end

    assign cpu.mem_rdata   = data_q[reqIndex][wordBase +: 32];
    assign cpu.hit         = cpu.mem_resp & ~missed_q;
    assign pmem.pmem_wdata = data_q[missIndex];

    always_comb begin
        valid_d  = valid_q;
        dirty_d  = dirty_q;
        missed_d = missed_q;
        if (writeHit) dirty_d[reqIndex] = 1'b1;
        if (wbDone) dirty_d[missIndex] = 1'b0;
        if (fillDone) begin
            valid_d[missIndex] = 1'b1;
            dirty_d[missIndex] = 1'b0;
        end
        if (cpu.mem_resp) missed_d = 1'b0;
        else if (startMiss) missed_d = 1'b1;
    end

    always_comb begin
        mergedWord = data_q[reqIndex][wordBase +: 32];
        for (int b = 0; b < 4; b++) begin
            if (cpu.mem_byte_enable[b]) mergedWord[b*8 +: 8] = cpu.mem_wdata[b*8 +: 8];
        end
    end

    // Tag/data arrays carry no reset: during reset every valid bit is clear, so no write can fire.
    always_ff @(posedge clk) begin
        if (startMiss) missAddr_q <= cpu.mem_address[31:S_OFFSET];
        if (fillDone) begin
            data_q[missIndex] <= pmem.pmem_rdata;
            tag_q[missIndex]  <= missTag;
        end
        if (writeHit) data_q[reqIndex][wordBase +: 32] <= mergedWord;
    end
endmodule

// File: tb/tb_l1_dcache.sv
// Scoreboard bench for l1_dcache: a flat golden memory plus an L2 responder predict every load.
// Directed corner cases first, then randomized traffic with stray L2 responses.
module tb_l1_dcache;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    l1_dcache_cpu_if  cif ();
    l1_dcache_pmem_if pif ();

    l1_dcache dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cpu   (cif),
        .pmem  (pif)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          isRead;
        logic [31:0] data;
        bit          hit;
        bit          checkHit;
    } exp_t;

    exp_t         expQ [$];
    int           checks = 0;
    int           fails = 0;
    int           cyc = 0;
    logic [255:0] l2Line   [logic [31:0]];
    logic [31:0]  goldWord [logic [31:0]];
    bit           mValid [16];
    bit           mDirty [16];
    logic [22:0]  mTag   [16];
    bit           missedFlag = 1'b0;
    int           fillCount = 0;
    int           wbCount = 0;
    int           lastFillCycle = 0;
    logic [31:0]  lastFillAddr = '0;
    logic [31:0]  lastWbAddr = '0;
    bit           reqActive = 1'b0;
    bit           strayEnable = 1'b0;

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [255:0] initLine(input logic [31:0] la);
        logic [255:0] ln;
        for (int i = 0; i < 8; i++) ln[i*32 +: 32] = (la * 32'h9E3779B1) ^ (32'h01000193 * 32'(i + 1));
        return ln;
    endfunction

    function automatic logic [255:0] l2Read(input logic [31:0] la);
        if (l2Line.exists(la)) return l2Line[la];
        return initLine(la);
    endfunction

    function automatic logic [31:0] goldRead(input logic [31:0] a);
        logic [31:0]  wa;
        logic [255:0] ln;
        wa = a & ~32'h3;
        if (goldWord.exists(wa)) return goldWord[wa];
        ln = l2Read(wa & ~32'h1F);
        return ln[wa[4:2]*32 +: 32];
    endfunction

    function automatic logic [255:0] goldLine(input logic [31:0] la);
        logic [255:0] ln;
        for (int i = 0; i < 8; i++) ln[i*32 +: 32] = goldRead(la + 32'(i * 4));
        return ln;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 16; i++) begin
            mValid[i] = 1'b0;
            mDirty[i] = 1'b0;
        end
        missedFlag = 1'b0;
        goldWord.delete();
    endtask

    // Behavioural L2: random latency, one-cycle pmem_resp, checks write-back contents.
    initial begin
        int cnt;
        int lat;
        bit isRd;
        logic [31:0] la;
        cnt = 0;
        lat = 2;
        pif.pmem_resp  = 1'b0;
        pif.pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (pif.pmem_read || pif.pmem_write) begin
                checkOutput("pmem read/write overlap", 256'(pif.pmem_read & pif.pmem_write), 256'(0));
                if (cnt == 0) lat = $urandom_range(2, 4);
                cnt++;
                if (cnt >= lat) begin
                    cnt  = 0;
                    isRd = pif.pmem_read;
                    la   = pif.pmem_address;
                    if (!isRd) begin
                        checkOutput("writeback line", pif.pmem_wdata, goldLine(la));
                        l2Line[la] = pif.pmem_wdata;
                        wbCount++;
                        lastWbAddr = la;
                    end
                    @(posedge clk);
                    #1;
                    pif.pmem_resp  = 1'b1;
                    pif.pmem_rdata = isRd ? l2Read(la) : {8{$urandom()}};
                    @(negedge clk);
                    if (isRd) begin
                        fillCount++;
                        lastFillAddr  = la;
                        lastFillCycle = cyc;
                    end
                    @(posedge clk);
                    #1;
                    pif.pmem_resp = 1'b0;
                end
            end else begin
                cnt = 0;
                if (strayEnable && !reqActive && $urandom_range(0, 7) == 0) begin
                    @(posedge clk);
                    #1;
                    pif.pmem_resp  = 1'b1;
                    pif.pmem_rdata = {8{$urandom()}};
                    @(posedge clk);
                    #1;
                    pif.pmem_resp = 1'b0;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every mem_resp consumes one expected entry.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && cif.mem_resp) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected mem_resp", 256'(1), 256'(0));
            end else begin
                e = expQ.pop_front();
                if (e.isRead) checkOutput("load data", 256'(cif.mem_rdata), 256'(e.data));
                if (e.checkHit) checkOutput("hit flag", 256'(cif.hit), 256'(e.hit));
                checkOutput("pmem idle at resp", 256'({pif.pmem_read, pif.pmem_write}), 256'(0));
            end
        end
    end

    task automatic applyStimulus(input bit wr, input bit rd, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be, input bit chkHit,
                                 output logic [31:0] rdata, output int cycles);
        logic [3:0]  idx;
        logic [22:0] tg;
        logic [31:0] oldW, mask;
        bit          hitP, expWb, got;
        int          fills0, wbs0, respCycle;
        exp_t        e;
        idx    = addr[8:5];
        tg     = addr[31:9];
        hitP   = mValid[idx] && (mTag[idx] == tg);
        expWb  = !hitP && mValid[idx] && mDirty[idx];
        fills0 = fillCount;
        wbs0   = wbCount;
        oldW   = goldRead(addr);
        e.isRead   = rd && !wr;
        e.data     = oldW;
        e.hit      = hitP && !missedFlag;
        e.checkHit = chkHit;
        expQ.push_back(e);
        mValid[idx] = 1'b1;
        mTag[idx]   = tg;
        if (wr) begin
            mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
            goldWord[addr & ~32'h3] = (oldW & ~mask) | (wdata & mask);
            mDirty[idx] = 1'b1;
        end else if (!hitP) begin
            mDirty[idx] = 1'b0;
        end
        missedFlag = 1'b0;

        @(posedge clk);
        #1;
        reqActive           = 1'b1;
        cif.mem_read        = rd;
        cif.mem_write       = wr;
        cif.mem_address     = addr;
        cif.mem_wdata       = wdata;
        cif.mem_byte_enable = be;
        cycles = 0;
        got    = 1'b0;
        while (!got && cycles < 100) begin
            @(negedge clk);
            if (cif.mem_resp) got = 1'b1;
            else cycles++;
        end
        rdata     = cif.mem_rdata;
        respCycle = cyc;
        if (!got) begin
            checkOutput("response timeout", 256'(0), 256'(1));
            expQ.delete();
        end
        @(posedge clk);
        #1;
        cif.mem_read  = 1'b0;
        cif.mem_write = 1'b0;
        reqActive     = 1'b0;
        checkOutput("fill count", 256'(fillCount - fills0), hitP ? 256'(0) : 256'(1));
        checkOutput("writeback count", 256'(wbCount - wbs0), 256'(expWb));
        if (hitP) begin
            checkOutput("zero-stall hit", 256'(cycles), 256'(0));
        end else if (got) begin
            checkOutput("fill address", 256'(lastFillAddr), 256'({addr[31:5], 5'b0}));
            checkOutput("fill to resp latency", 256'(respCycle - lastFillCycle), 256'(1));
        end
    endtask

    task automatic waitPmemRead(input bit level, input string name);
        int n;
        n = 0;
        while (pif.pmem_read !== level && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (pif.pmem_read !== level) checkOutput(name, 256'(pif.pmem_read), 256'(level));
    endtask

    task automatic dropDuringAllocate(input logic [31:0] addr);
        int f0;
        f0 = fillCount;
        mValid[addr[8:5]] = 1'b1;
        mTag[addr[8:5]]   = addr[31:9];
        mDirty[addr[8:5]] = 1'b0;
        missedFlag        = 1'b1;
        @(posedge clk);
        #1;
        reqActive       = 1'b1;
        cif.mem_read    = 1'b1;
        cif.mem_address = addr;
        waitPmemRead(1'b1, "allocate start before drop");
        @(posedge clk);
        #1;
        cif.mem_read = 1'b0;
        waitPmemRead(1'b0, "allocate finish after drop");
        repeat (4) @(negedge clk);
        reqActive = 1'b0;
        checkOutput("fill after drop", 256'(fillCount - f0), 256'(1));
    endtask

    task automatic resetDuringAllocate(input logic [31:0] addr);
        @(posedge clk);
        #1;
        reqActive       = 1'b1;
        cif.mem_read    = 1'b1;
        cif.mem_address = addr;
        waitPmemRead(1'b1, "allocate start before reset");
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("pmem_read under reset", 256'(pif.pmem_read), 256'(0));
        checkOutput("mem_resp under reset", 256'(cif.mem_resp), 256'(0));
        cif.mem_read = 1'b0;
        reqActive    = 1'b0;
        modelReset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0]  rdata, addr;
        logic [255:0] ln;
        int           cycles, kind;
        cif.mem_read        = 1'b0;
        cif.mem_write       = 1'b0;
        cif.mem_byte_enable = 4'h0;
        cif.mem_address     = '0;
        cif.mem_wdata       = '0;
        modelReset();
        ln = initLine(32'h100);
        ln[63:32] = 32'hCAFE0001;
        ln[95:64] = 32'h11223344;
        l2Line[32'h100] = ln;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset mem_resp", 256'(cif.mem_resp), 256'(0));
        checkOutput("reset hit", 256'(cif.hit), 256'(0));
        checkOutput("reset pmem_read", 256'(pif.pmem_read), 256'(0));
        checkOutput("reset pmem_write", 256'(pif.pmem_write), 256'(0));
        rst_n = 1'b1;

        applyStimulus(1'b0, 1'b1, 32'h0000_0104, '0, 4'h0, 1'b1, rdata, cycles);
        checkOutput("first read word1", 256'(rdata), 256'(32'hCAFE0001));
        applyStimulus(1'b0, 1'b1, 32'h0000_0104, '0, 4'h0, 1'b1, rdata, cycles);
        applyStimulus(1'b1, 1'b0, 32'h0000_0108, 32'hAABBCCDD, 4'b0101, 1'b1, rdata, cycles);
        checkOutput("write hit latency", 256'(cycles), 256'(0));
        applyStimulus(1'b0, 1'b1, 32'h0000_0108, '0, 4'h0, 1'b1, rdata, cycles);
        checkOutput("merged word", 256'(rdata), 256'(32'h11BB33DD));
        applyStimulus(1'b0, 1'b1, 32'h0000_1100, '0, 4'h0, 1'b1, rdata, cycles);
        checkOutput("writeback address", 256'(lastWbAddr), 256'(32'h0000_0100));

        dropDuringAllocate(32'h0000_2244);
        applyStimulus(1'b0, 1'b1, 32'h0000_2244, '0, 4'h0, 1'b0, rdata, cycles);

        resetDuringAllocate(32'h0000_3300);
        applyStimulus(1'b0, 1'b1, 32'h0000_3300, '0, 4'h0, 1'b1, rdata, cycles);
        applyStimulus(1'b1, 1'b1, 32'h0000_3304, 32'h0BADF00D, 4'hF, 1'b1, rdata, cycles);
        applyStimulus(1'b0, 1'b1, 32'h0000_3306, '0, 4'h0, 1'b1, rdata, cycles);

        strayEnable = 1'b1;
        for (int i = 0; i < 300; i++) begin
            addr = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 15)) << 5)
                 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            kind = $urandom_range(0, 3);
            applyStimulus(kind >= 2, kind != 2, addr, $urandom(), 4'($urandom_range(0, 15)),
                          1'b1, rdata, cycles);
        end
        strayEnable = 1'b0;

        repeat (5) @(negedge clk);
        checkOutput("scoreboard drained", 256'(expQ.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation watchdog expired");
    end
endmodule
